// File: rtl/neuron_bus_driver.sv
// Command FIFO plus sequencer that replays weight/membrane loads and spike events onto a neuron unit bus.
// Optional: define NEURON_LEAK_EN to subtract LEAK (floored at 0) from non-spiking membrane write-backs.
module neuron_bus_driver #(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] REST_VALUE = '0,
    parameter logic [DATA_WIDTH-1:0] LEAK       = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready depends only on the registered FIFO count, never on cmd_valid.
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-2:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  risc_v_read,
    output logic                  risc_v_write,
    output logic [ADDR_WIDTH-1:0] risc_v_addr,
    output logic [DATA_WIDTH-1:0] risc_v_data_in,
    input  logic [DATA_WIDTH-1:0] risc_v_data_out,
    input  logic                  spike_detected,
    output logic                  spike_out,
    output logic [15:0]           spike_count,
    output logic                  busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef NEURON_LEAK_EN
    localparam bit LEAK_ON = 1'b1;
`else
    localparam bit LEAK_ON = 1'b0;
`endif

    localparam logic [1:0] OP_WEIGHT = 2'b00;
    localparam logic [1:0] OP_MEMB   = 2'b01;
    localparam logic [1:0] OP_SPIKE  = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] MEMB_ADDR = {1'b1, {(ADDR_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_READ   = 2'd2,
        ST_WRBACK = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [1:0]            r_fifo_op   [FIFO_DEPTH];
    logic [ADDR_WIDTH-2:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic [1:0]            r_op;
    logic [ADDR_WIDTH-2:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_spike_flag;
    logic [15:0]           r_spike_count;

    logic                  w_push;
    logic                  w_pop;
    logic [1:0]            w_head_op;
    logic [DATA_WIDTH-1:0] w_leaked;
    logic [DATA_WIDTH-1:0] w_wb_value;

    assign cmd_ready = (r_count != CNT_W'(FIFO_DEPTH));
    assign w_push    = cmd_valid && cmd_ready;
    assign w_pop     = (r_state == ST_IDLE) && (r_count != '0);
    assign w_head_op = r_fifo_op[r_rd_ptr];

    // Storage needs no reset: emptiness is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_op[r_wr_ptr]   <= cmd_op;
            r_fifo_addr[r_wr_ptr] <= cmd_addr;
            r_fifo_data[r_wr_ptr] <= cmd_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_op          <= OP_WEIGHT;
            r_addr        <= '0;
            r_data        <= '0;
            r_spike_flag  <= 1'b0;
            r_spike_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                r_op   <= w_head_op;
                r_addr <= r_fifo_addr[r_rd_ptr];
                r_data <= r_fifo_data[r_rd_ptr];
            end
            if (r_state == ST_READ) r_spike_flag <= spike_detected;
            if (w_pop && (w_head_op == OP_CLEAR)) begin
                r_spike_count <= '0;
            end else if ((r_state == ST_WRBACK) && r_spike_flag && (r_spike_count != 16'hFFFF)) begin
                r_spike_count <= r_spike_count + 16'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    case (w_head_op)
                        OP_WEIGHT, OP_MEMB: w_state_next = ST_WRITE;
                        OP_SPIKE:           w_state_next = ST_READ;
                        default:            w_state_next = ST_IDLE;
                    endcase
                end
            end
            ST_WRITE:  w_state_next = ST_IDLE;
            ST_READ:   w_state_next = ST_WRBACK;
            ST_WRBACK: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // The unit wraps its sum; leak only floors the subtraction at zero.
    assign w_leaked   = (risc_v_data_out > LEAK) ? (risc_v_data_out - LEAK) : '0;
    assign w_wb_value = LEAK_ON ? w_leaked : risc_v_data_out;

    always_comb begin
        risc_v_read    = 1'b0;
        risc_v_write   = 1'b0;
        risc_v_addr    = '0;
        risc_v_data_in = '0;
        case (r_state)
            ST_WRITE: begin
                risc_v_write   = 1'b1;
                risc_v_data_in = r_data;
                risc_v_addr    = (r_op == OP_MEMB) ? MEMB_ADDR : {1'b0, r_addr};
            end
            ST_READ: begin
                risc_v_read = 1'b1;
                risc_v_addr = {1'b0, r_addr};
            end
            ST_WRBACK: begin
                risc_v_write   = 1'b1;
                risc_v_addr    = MEMB_ADDR;
                risc_v_data_in = r_spike_flag ? REST_VALUE : w_wb_value;
            end
            default: ;
        endcase
    end

    assign spike_out   = (r_state == ST_WRBACK) && r_spike_flag;
    assign spike_count = r_spike_count;
    assign busy        = (r_count != '0) || (r_state != ST_IDLE);

endmodule
